filter_out_capture: RTL
=======================

Name: filter_out_capture

Overview:
- Receiving end of the filter sample handshake (START_FLAG / DATA_OUT / DATA_VALID) used by the IIR_*_MULT_* cores.
- Captures each filter result on the rising edge of DATA_VALID into a small synchronous FIFO, so a downstream reader (UART/host bridge) can drain results at its own pace.
- Watchdog checks that every START_FLAG strobe is answered by a DATA_VALID before the next one or a timeout; errors are held in sticky flags.

Parameters:
- BITSIZE, 16, sample width; equals the filter data width.
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- TIMEOUT, 64, maximum clocks from START_FLAG rise to DATA_VALID rise; range 2..65535.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- EN  in  1  capture and watchdog enable.
- START_FLAG  in  1  ADC strobe seen by the filter; only its rising edge is used.
- DATA_IN  in  BITSIZE  filter DATA_OUT.
- DATA_VALID  in  1  filter DATA_VALID; only its rising edge is used.
- RD_EN  in  1  read request, one entry per cycle.
- RD_DATA  out  BITSIZE  read data, registered.
- RD_VALID  out  1  one-cycle pulse; RD_DATA is valid.
- FIFO_EMPTY  out  1  no entries.
- FIFO_FULL  out  1  DEPTH entries.
- FILL_LEVEL  out  clog2(DEPTH)+1  current entry count.
- SAMPLE_CNT  out  16  accepted captures; wraps from 0xFFFF to 0.
- OVERFLOW  out  1  sticky: a capture was dropped because the FIFO was full.
- TIMEOUT_ERR  out  1  sticky: the watchdog fired.
- CLR_ERR  in  1  clears OVERFLOW and TIMEOUT_ERR.

Behaviour:
- Reset (nRST=0 at a clock edge) sets all of the following to 0:
  - pointers, FILL_LEVEL, SAMPLE_CNT, RD_DATA, RD_VALID, OVERFLOW, TIMEOUT_ERR, FIFO_FULL;
  - edge-detect registers.
  - FIFO_EMPTY=1 and the FSM goes to IDLE.
  - FIFO memory contents are not reset.
  - Reset mid-operation discards all stored entries.
- Edge detection:
  - dv_q and sf_q register DATA_VALID and START_FLAG every cycle, regardless of EN.
  - dv_rise = DATA_VALID & ~dv_q; sf_rise = START_FLAG & ~sf_q.
  - A level held high across an EN 0->1 transition is not a new edge.
- Capture:
  - When EN=1 and dv_rise, DATA_IN from the same cycle is written.
  - The entry is visible in FILL_LEVEL/FIFO_EMPTY on the next cycle.
  - SAMPLE_CNT increments on each accepted write.
- Full:
  - A write while full with no read in the same cycle is dropped; OVERFLOW is set next cycle and the contents are unchanged.
  - A write and read in the same cycle while full are both accepted; FILL_LEVEL stays at DEPTH.
- Read:
  - RD_EN while not empty: RD_DATA gets the oldest entry and RD_VALID=1 on the next cycle; the read pointer advances.
  - RD_EN while empty is ignored: RD_VALID=0 and RD_DATA holds its value.
  - A simultaneous read and write while empty returns no data; the write is accepted.
  - Reads work regardless of EN.
- Pointers are clog2(DEPTH)+1 bits and wrap naturally; full/empty are decoded from MSB equality.
- Watchdog FSM (counter is 16 bits):
  - IDLE:
    - If EN=1 and sf_rise: go to WAIT, cnt=0.
  - WAIT:
    - cnt increments each cycle.
    - dv_rise: go to IDLE. It wins over a timeout in the same cycle.
    - sf_rise without dv_rise (missed result): set TIMEOUT_ERR, restart with cnt=0, stay in WAIT.
    - sf_rise together with dv_rise: the result is accepted and the FSM stays in WAIT with cnt=0 (back-to-back samples).
    - cnt==TIMEOUT-1 with no dv_rise: set TIMEOUT_ERR, go to IDLE.
    - EN=0: go to IDLE with no error.
- CLR_ERR clears both sticky flags next cycle. If a set event occurs in the same cycle, the set wins.
- EN=0 blocks capture and the watchdog; stored data and flags are retained.

Optional Feature:
- Macro: CAPTURE_SIGNED_EN.
- Defined: DATA_IN MSB is inverted on write, converting offset-binary (midscale = 1<<(BITSIZE-1)) to two's complement.
- Undefined: data is stored unmodified (offset-binary). Nothing else changes.

Test Plan:
- Reset, then EN=1, BITSIZE=16. Apply 3 DATA_VALID rises with DATA_IN 0x8000, 0x8123, 0x7FF0, then RD_EN for 3 cycles.
  - Expect RD_DATA 0x8000, 0x8123, 0x7FF0 with RD_VALID pulses, then FIFO_EMPTY=1 and SAMPLE_CNT=3.
  - With CAPTURE_SIGNED_EN, expect 0x0000, 0x0123, 0xFFF0.
- DEPTH=16: write 17 samples with no reads.
  - Expect FIFO_FULL=1, FILL_LEVEL=16, OVERFLOW=1, SAMPLE_CNT=16; the first read returns sample #1.
  - CLR_ERR pulse gives OVERFLOW=0.
- Full FIFO, RD_EN and dv_rise in the same cycle.
  - Expect FILL_LEVEL to stay 16, OVERFLOW=0, and the new sample to be read 16th.
- START_FLAG pulse with no DATA_VALID, TIMEOUT=64.
  - Expect TIMEOUT_ERR=1 exactly 64 cycles after the rise, and the FSM in IDLE.
  - Repeat with DATA_VALID at cycle 40: TIMEOUT_ERR stays 0.
- Two START_FLAG rises 20 cycles apart with no DATA_VALID in between.
  - Expect TIMEOUT_ERR=1 at the second rise.
- Hold DATA_VALID=1 while toggling EN 0->1.
  - Expect no capture (FILL_LEVEL=0).
- Assert nRST=0 for 1 cycle with FIFO level 5.
  - Expect FIFO_EMPTY=1, FILL_LEVEL=0 and SAMPLE_CNT=0 on the next cycle.

Source files
------------

// File: rtl/filter_out_capture_if.sv
// Filter-sample and read-side handshake bundle for filter_out_capture.
// master: filter + reader side (drives strobes, DATA_IN, RD_EN); slave: capture block.
interface filter_out_capture_if #(
    parameter int BITSIZE = 16
);
    logic               START_FLAG;
    logic [BITSIZE-1:0] DATA_IN;
    logic               DATA_VALID;
    logic               RD_EN;
    logic [BITSIZE-1:0] RD_DATA;
    logic               RD_VALID;

    modport master (
        output START_FLAG, DATA_IN, DATA_VALID, RD_EN,
        input  RD_DATA, RD_VALID
    );

    modport slave (
        input  START_FLAG, DATA_IN, DATA_VALID, RD_EN,
        output RD_DATA, RD_VALID
    );
endinterface

// File: rtl/filter_out_capture.sv
// Captures filter results on DATA_VALID rise into a FIFO; watchdog on START_FLAG.
// Ports: CLK, nRST (sync, active-low), EN, CLR_ERR, bus (slave: START_FLAG, DATA_IN,
//   DATA_VALID, RD_EN -> RD_DATA, RD_VALID), FIFO_EMPTY, FIFO_FULL, FILL_LEVEL,
//   SAMPLE_CNT, OVERFLOW, TIMEOUT_ERR. Optional: CAPTURE_SIGNED_EN flips the MSB
//   on write (offset-binary to two's complement).
module filter_out_capture #(
    parameter int BITSIZE = 16,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     EN,
    input  logic                     CLR_ERR,
    filter_out_capture_if.slave      bus,
    output logic                     FIFO_EMPTY,
    output logic                     FIFO_FULL,
    output logic [$clog2(DEPTH):0]   FILL_LEVEL,
    output logic [15:0]              SAMPLE_CNT,
    output logic                     OVERFLOW,
    output logic                     TIMEOUT_ERR
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01
    } state_t;

    logic [BITSIZE-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               dv_q;
    logic               sf_q;
    logic               dv_rise;
    logic               sf_rise;
    logic               wr_req;
    logic               do_wr;
    logic               do_rd;
    logic               ovf_set;
    logic [BITSIZE-1:0] wdata;

    state_t             state;
    state_t             state_nx;
    logic [15:0]        cnt;
    logic [15:0]        cnt_nx;
    logic               to_set;

    assign dv_rise = bus.DATA_VALID & ~dv_q;
    assign sf_rise = bus.START_FLAG & ~sf_q;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign FIFO_EMPTY = (wr_ptr == rd_ptr);
    assign FIFO_FULL  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign FILL_LEVEL = wr_ptr - rd_ptr;

    assign wr_req  = EN & dv_rise;
    assign do_rd   = bus.RD_EN & ~FIFO_EMPTY;
    // A read in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign do_wr   = wr_req & (~FIFO_FULL | do_rd);
    assign ovf_set = wr_req & FIFO_FULL & ~do_rd;

`ifdef CAPTURE_SIGNED_EN
    assign wdata = {~bus.DATA_IN[BITSIZE-1], bus.DATA_IN[BITSIZE-2:0]};
`else
    assign wdata = bus.DATA_IN;
`endif

    // Storage is not reset; pointers alone define contents.
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dv_q        <= 1'b0;
            sf_q        <= 1'b0;
            SAMPLE_CNT  <= '0;
            bus.RD_DATA <= '0;
            bus.RD_VALID <= 1'b0;
            OVERFLOW    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            dv_q         <= bus.DATA_VALID;
            sf_q         <= bus.START_FLAG;
            bus.RD_VALID <= do_rd;
            if (do_wr) begin
                wr_ptr     <= wr_ptr + 1'b1;
                SAMPLE_CNT <= SAMPLE_CNT + 16'd1;
            end
            if (do_rd) begin
                rd_ptr      <= rd_ptr + 1'b1;
                bus.RD_DATA <= mem[rd_ptr[AW-1:0]];
            end
            // Set has priority over clear.
            if (ovf_set) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                OVERFLOW <= 1'b0;
            end
            if (to_set) begin
                TIMEOUT_ERR <= 1'b1;
            end else if (CLR_ERR) begin
                TIMEOUT_ERR <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        to_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (EN && sf_rise) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end
            end
            WAIT: begin
                cnt_nx = cnt + 16'd1;
                if (!EN) begin
                    state_nx = IDLE;
                end else if (dv_rise) begin
                    // A new strobe with its answer starts the next window.
                    if (sf_rise) begin
                        cnt_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (sf_rise) begin
                    to_set = 1'b1;
                    cnt_nx = '0;
                end else if (cnt == TO_LAST) begin
                    to_set   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end
endmodule
